// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: writeback select codes, funct3
// access-size codes and the request/response FSM encoding.
package mem_stage_pkg;

    localparam logic [1:0] WBSEL_ALU = 2'd0;
    localparam logic [1:0] WBSEL_MEM = 2'd1;
    localparam logic [1:0] WBSEL_PC  = 2'd2;

    // funct3[1:0] carries the access size, funct3[2] selects zero-extension
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the data memory: store byte enables and replicated
// write data, load lane extraction with sign/zero extension, misalignment.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       addr_lo_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] st_data_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             misalign_o,
    output logic [3:0]       be_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [WIDTH-1:0] ld_data_o
);

    logic [WIDTH-1:0] rdata_shift;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    assign rdata_shift = rdata_i >> {addr_lo_i, 3'b000};
    assign ld_byte     = rdata_shift[7:0];
    assign ld_half     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        misalign_o = 1'b0;
        be_o       = 4'hF;
        wdata_o    = st_data_i;
        ld_data_o  = rdata_i;
        case (funct3_i[1:0])
            SIZE_B: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = funct3_i[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SIZE_H: begin
                misalign_o = addr_lo_i[0];
                be_o       = 4'b0011 << addr_lo_i;
                wdata_o    = {2{st_data_i[15:0]}};
                ld_data_o  = funct3_i[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-memory requests, stalls upstream while a
// load is outstanding, and drives the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [WIDTH-1:0]    alu_out_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                rf_w_en_i,
    input  logic [1:0]          wbsel_i,
    input  logic                mem_w_en_i,
    input  logic [WIDTH-1:0]    rs2_data_i,
    input  logic [2:0]          funct3_i,
    output logic                stall_o,
    output logic                misalign_o,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [ADDR_LEN-1:0] dmem_addr,
    output logic                dmem_we,
    output logic [3:0]          dmem_be,
    output logic [WIDTH-1:0]    dmem_wdata,
    input  logic                dmem_rsp_valid,
    input  logic [WIDTH-1:0]    dmem_rdata,
    output logic                valid_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [WIDTH-1:0]    alu_out_o,
    output logic [WIDTH-1:0]    mem_rdata_o,
    output logic [4:0]          rd_addr_o,
    output logic                rf_w_en_o,
    output logic [1:0]          wbsel_o
);

    state_e state_q, state_d;

    logic             is_load, is_store, misal;
    logic             capture, rsp_fire, misalign_d;
    logic             rf_w_en_d;
    logic [WIDTH-1:0] ld_data, mem_rdata_d;

    logic                valid_q, rf_w_en_q, misalign_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic [WIDTH-1:0]    alu_out_q, mem_rdata_q;
    logic [4:0]          rd_addr_q;
    logic [1:0]          wbsel_q;

    assign is_load  = (wbsel_i == WBSEL_MEM);
    assign is_store = mem_w_en_i;

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .addr_lo_i  (alu_out_i[1:0]),
        .funct3_i   (funct3_i),
        .st_data_i  (rs2_data_i),
        .rdata_i    (dmem_rdata),
        .misalign_o (misal),
        .be_o       (dmem_be),
        .wdata_o    (dmem_wdata),
        .ld_data_o  (ld_data)
    );

    // Request fields come straight from EX/MEM; upstream holds them while stalled
    assign dmem_addr = {alu_out_i[ADDR_LEN-1:2], 2'b00};
    assign dmem_we   = mem_w_en_i;

    always_comb begin
        state_d        = state_q;
        stall_o        = 1'b0;
        dmem_req_valid = 1'b0;
        capture        = 1'b0;
        rsp_fire       = 1'b0;
        misalign_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (is_load || is_store) begin
                        if (misal) begin
                            capture    = 1'b1;
                            misalign_d = 1'b1;
                        end else begin
                            dmem_req_valid = 1'b1;
                            if (!dmem_req_ready) begin
                                stall_o = 1'b1;
                            end else if (is_store) begin
                                capture = 1'b1;
                            end else begin
                                stall_o = 1'b1;
                                state_d = WAIT_RSP;
                            end
                        end
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    capture  = 1'b1;
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A misaligned access retires without writing the register file
    assign rf_w_en_d   = capture & rf_w_en_i & ~misalign_d;
    assign mem_rdata_d = rsp_fire ? ld_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            alu_out_q   <= '0;
            mem_rdata_q <= '0;
            rd_addr_q   <= '0;
            rf_w_en_q   <= 1'b0;
            wbsel_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= capture;
            pc_q        <= pc_i;
            alu_out_q   <= alu_out_i;
            mem_rdata_q <= mem_rdata_d;
            rd_addr_q   <= rd_addr_i;
            rf_w_en_q   <= rf_w_en_d;
            wbsel_q     <= wbsel_i;
            misalign_q  <= misalign_d;
        end
    end

    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign alu_out_o   = alu_out_q;
    assign mem_rdata_o = mem_rdata_q;
    assign rd_addr_o   = rd_addr_q;
    assign rf_w_en_o   = rf_w_en_q;
    assign wbsel_o     = wbsel_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB contents into a
// queue, a monitor pops and compares each valid MEM/WB output.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [31:0] pc_i, alu_out_i, rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        rf_w_en_i, mem_w_en_i;
    logic [1:0]  wbsel_i;
    logic [2:0]  funct3_i;
    logic        stall_o, misalign_o;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        valid_o, rf_w_en_o;
    logic [31:0] pc_o, alu_out_o, mem_rdata_o;
    logic [4:0]  rd_addr_o;
    logic [1:0]  wbsel_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rf;
        logic [1:0]  wbsel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_stage #(.WIDTH(32), .ADDR_LEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .pc_i           (pc_i),
        .alu_out_i      (alu_out_i),
        .rd_addr_i      (rd_addr_i),
        .rf_w_en_i      (rf_w_en_i),
        .wbsel_i        (wbsel_i),
        .mem_w_en_i     (mem_w_en_i),
        .rs2_data_i     (rs2_data_i),
        .funct3_i       (funct3_i),
        .stall_o        (stall_o),
        .misalign_o     (misalign_o),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .valid_o        (valid_o),
        .pc_o           (pc_o),
        .alu_out_o      (alu_out_o),
        .mem_rdata_o    (mem_rdata_o),
        .rd_addr_o      (rd_addr_o),
        .rf_w_en_o      (rf_w_en_o),
        .wbsel_o        (wbsel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdv,
                            input logic [4:0] rd, input logic rf, input logic [1:0] wb);
        exp_t e;
        e = {pc, alu, rdv, rd, rf, wb};
        exp_q.push_back(e);
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [4:0] rd, input logic rf, input logic [1:0] wb,
                          input logic mw, input logic [31:0] rs2, input logic [2:0] f3);
        valid_i = v; pc_i = pc; alu_out_i = alu; rd_addr_i = rd; rf_w_en_i = rf;
        wbsel_i = wb; mem_w_en_i = mw; rs2_data_i = rs2; funct3_i = f3;
    endtask

    task automatic bubble();
        set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, WBSEL_ALU, 1'b0, 32'h0, F3_LB);
    endtask

    // Store accepted in its first cycle
    task automatic store_fast(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] rs2, input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        set_in(1'b1, pc, addr, 5'd0, 1'b0, WBSEL_ALU, 1'b1, rs2, f3);
        dmem_req_ready = 1'b1;
        #1;
        chk("st_stall", {31'b0, stall_o}, 32'd0);
        chk("st_be", {28'b0, dmem_be}, {28'b0, be});
        chk("st_wdata", dmem_wdata, wd);
        push_exp(pc, addr, 32'h0, 5'd0, 1'b0, WBSEL_ALU);
        @(negedge clk);
        bubble();
        dmem_req_ready = 1'b0;
    endtask

    // Load accepted immediately, response waitc cycles after acceptance
    task automatic do_load(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdv, input int waitc,
                           input logic [31:0] expv);
        @(negedge clk);
        set_in(1'b1, pc, addr, rd, 1'b1, WBSEL_MEM, 1'b0, 32'h0, f3);
        dmem_req_ready = 1'b1;
        #1;
        chk("ld_req", {31'b0, dmem_req_valid}, 32'd1);
        chk("ld_stall_acc", {31'b0, stall_o}, 32'd1);
        chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
        push_exp(pc, addr, expv, rd, 1'b1, WBSEL_MEM);
        for (int i = 1; i < waitc; i++) begin
            @(negedge clk);
            dmem_req_ready = 1'b0;
            #1;
            chk("ld_wait_stall", {31'b0, stall_o}, 32'd1);
            chk("ld_wait_noreq", {31'b0, dmem_req_valid}, 32'd0);
        end
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdv;
        #1;
        chk("ld_rsp_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        bubble();
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && valid_o === 1'b1) begin
            exp_t a, e;
            a = {pc_o, alu_out_o, mem_rdata_o, rd_addr_o, rf_w_en_o, wbsel_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got pc=%h alu=%h with no expected entry", pc_o, alu_out_o);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL mon_memwb: got pc=%h alu=%h rdata=%h rd=%0d rf=%b wb=%0d expected pc=%h alu=%h rdata=%h rd=%0d rf=%b wb=%0d",
                             a.pc, a.alu, a.rdata, a.rd, a.rf, a.wbsel,
                             e.pc, e.alu, e.rdata, e.rd, e.rf, e.wbsel);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bubble();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_rf", {31'b0, rf_w_en_o}, 32'd0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_alu", alu_out_o, 32'h0);
        chk("rst_rdata", mem_rdata_o, 32'h0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Plain ALU op
        @(negedge clk);
        set_in(1'b1, 32'h40, 32'h1234, 5'd5, 1'b1, WBSEL_ALU, 1'b0, 32'h0, F3_LW);
        #1;
        chk("alu_stall", {31'b0, stall_o}, 32'd0);
        chk("alu_noreq", {31'b0, dmem_req_valid}, 32'd0);
        push_exp(32'h40, 32'h1234, 32'h0, 5'd5, 1'b1, WBSEL_ALU);
        @(negedge clk);
        bubble();
        #1;
        chk("alu_out", alu_out_o, 32'h1234);

        // SB at 0x103 with ready low for two cycles
        @(negedge clk);
        set_in(1'b1, 32'h44, 32'h103, 5'd0, 1'b0, WBSEL_ALU, 1'b1, 32'hAB, F3_LB);
        dmem_req_ready = 1'b0;
        #1;
        chk("sb_stall1", {31'b0, stall_o}, 32'd1);
        chk("sb_req", {31'b0, dmem_req_valid}, 32'd1);
        chk("sb_be", {28'b0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_we", {31'b0, dmem_we}, 32'd1);
        @(negedge clk);
        #1;
        chk("sb_stall2", {31'b0, stall_o}, 32'd1);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        chk("sb_accept_stall", {31'b0, stall_o}, 32'd0);
        push_exp(32'h44, 32'h103, 32'h0, 5'd0, 1'b0, WBSEL_ALU);
        @(negedge clk);
        bubble();
        dmem_req_ready = 1'b0;

        store_fast(32'h48, 32'h102, 3'b001, 32'h1234ABCD, 4'hC, 32'hABCDABCD);
        store_fast(32'h4C, 32'h108, 3'b010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);

        // Loads with lane select and extension
        do_load(32'h50, 32'h102, F3_LH,  5'd7, 32'h80010000, 3, 32'hFFFF8001);
        do_load(32'h54, 32'h102, F3_LHU, 5'd8, 32'h80010000, 3, 32'h00008001);
        do_load(32'h58, 32'h101, F3_LB,  5'd9, 32'h0000F500, 1, 32'hFFFFFFF5);
        do_load(32'h5C, 32'h103, F3_LBU, 5'd10, 32'h7F000000, 2, 32'h0000007F);

        // Misaligned LW
        @(negedge clk);
        set_in(1'b1, 32'h60, 32'h101, 5'd11, 1'b1, WBSEL_MEM, 1'b0, 32'h0, F3_LW);
        dmem_req_ready = 1'b1;
        #1;
        chk("mis_noreq", {31'b0, dmem_req_valid}, 32'd0);
        chk("mis_stall", {31'b0, stall_o}, 32'd0);
        push_exp(32'h60, 32'h101, 32'h0, 5'd11, 1'b0, WBSEL_MEM);
        @(negedge clk);
        bubble();
        dmem_req_ready = 1'b0;
        #1;
        chk("mis_pulse", {31'b0, misalign_o}, 32'd1);
        chk("mis_valid", {31'b0, valid_o}, 32'd1);
        chk("mis_rf", {31'b0, rf_w_en_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("mis_pulse_end", {31'b0, misalign_o}, 32'd0);

        // Back-to-back LW, LW, ALU with single-cycle responses
        @(negedge clk);
        set_in(1'b1, 32'h70, 32'h200, 5'd1, 1'b1, WBSEL_MEM, 1'b0, 32'h0, F3_LW);
        dmem_req_ready = 1'b1;
        #1;
        chk("b2b_ld1_stall", {31'b0, stall_o}, 32'd1);
        push_exp(32'h70, 32'h200, 32'h11111111, 5'd1, 1'b1, WBSEL_MEM);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h11111111;
        #1;
        chk("b2b_ld1_rsp", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        set_in(1'b1, 32'h74, 32'h204, 5'd2, 1'b1, WBSEL_MEM, 1'b0, 32'h0, F3_LW);
        dmem_req_ready = 1'b1;
        #1;
        chk("b2b_ld2_stall", {31'b0, stall_o}, 32'd1);
        push_exp(32'h74, 32'h204, 32'h22222222, 5'd2, 1'b1, WBSEL_MEM);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h22222222;
        #1;
        chk("b2b_ld2_rsp", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        set_in(1'b1, 32'h78, 32'h99, 5'd3, 1'b1, WBSEL_ALU, 1'b0, 32'h0, F3_LW);
        #1;
        chk("b2b_alu_stall", {31'b0, stall_o}, 32'd0);
        push_exp(32'h78, 32'h99, 32'h0, 5'd3, 1'b1, WBSEL_ALU);
        @(negedge clk);
        bubble();

        // Reset during WAIT_RSP, late response ignored
        @(negedge clk);
        set_in(1'b1, 32'h80, 32'h300, 5'd4, 1'b1, WBSEL_MEM, 1'b0, 32'h0, F3_LW);
        dmem_req_ready = 1'b1;
        #1;
        chk("rw_stall", {31'b0, stall_o}, 32'd1);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        chk("rw_waiting", {31'b0, stall_o}, 32'd1);
        bubble();
        reset = 1'b0;
        #1;
        chk("rw_rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rw_rst_valid", {31'b0, valid_o}, 32'd0);
        @(negedge clk);
        reset          = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hCAFEF00D;
        #1;
        chk("rw_late_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        #1;
        chk("rw_late_valid", {31'b0, valid_o}, 32'd0);
        chk("rw_late_rdata", mem_rdata_o, 32'h0);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the in-order pipeline: consumes the EX/MEM register outputs of the execute stage (pc, ALU result, rd address, rf write enable, writeback select, memory write enable, rs2 data), performs loads and stores against the data memory over a valid/ready request and valid response interface, and drives the MEM/WB pipeline register. It stalls upstream while a memory access is outstanding, and handles byte, halfword and word lane alignment with load sign/zero extension.

## Interface
- WIDTH, 32, data width
- ADDR_LEN, 32, address width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low; low clears all state immediately
- valid_i  in  1  EX/MEM holds a live instruction
- pc_i  in  ADDR_LEN  instruction pc
- alu_out_i  in  WIDTH  ALU result; effective address for loads/stores
- rd_addr_i  in  5  destination register
- rf_w_en_i  in  1  register-file write enable
- wbsel_i  in  2  writeback select; WBSEL_MEM marks a load
- mem_w_en_i  in  1  store
- rs2_data_i  in  WIDTH  store data
- funct3_i  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- stall_o  out  1  hold EX/MEM and earlier stages (combinational)
- misalign_o  out  1  registered one-cycle pulse on misaligned access
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  ADDR_LEN  word-aligned address {alu_out_i[ADDR_LEN-1:2],2'b00}
- dmem_we  out  1  write request
- dmem_be  out  4  byte enables
- dmem_wdata  out  WIDTH  lane-shifted store data
- dmem_rsp_valid  in  1  read data valid
- dmem_rdata  in  WIDTH  read word
- valid_o, pc_o, alu_out_o, mem_rdata_o, rd_addr_o, rf_w_en_o, wbsel_o  out  1/ADDR_LEN/WIDTH/WIDTH/5/1/2  MEM/WB register

## Operation
- FSM states: IDLE, WAIT_RSP.
- IDLE, valid_i=0: MEM/WB captures a bubble (valid_o=0, rf_w_en_o=0).
- IDLE, valid_i=1, neither load nor store: captured into MEM/WB; stall_o=0.
- IDLE, load or store, aligned: dmem_req_valid=1 combinationally. Until dmem_req_ready, stall_o=1 and a bubble is captured.
- Store accepted: completes that cycle (posted write), is captured into MEM/WB, stall_o=0.
- Load accepted: stall_o stays 1; go to WAIT_RSP.
- WAIT_RSP: dmem_req_valid=0; stall_o=1 and bubbles until dmem_rsp_valid. On the response cycle, stall_o=0, the aligned/extended data is captured into mem_rdata_o with the held EX/MEM fields, and the FSM returns to IDLE.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0. A misaligned access issues no request and sets misalign_o for one cycle. The instruction passes as valid_o=1 with rf_w_en_o forced to 0.
- Stores: SB has be=1<<addr[1:0] and replicates the byte to all lanes; SH has be=3<<addr[1:0] and replicates the halfword; SW has be=4'hF.
- Loads: select the byte or halfword at addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- dmem_rsp_valid in IDLE is ignored.

## Timing
- Reset: state=IDLE; valid_o, pc_o, alu_out_o, mem_rdata_o, rd_addr_o, rf_w_en_o, wbsel_o, misalign_o all 0. Combinational outputs follow from IDLE with registered state cleared.
- Non-memory latency: 1 cycle from EX/MEM to MEM/WB.
- Store with ready in the same cycle: 1 cycle, no stall.
- Load: earliest response is the cycle after acceptance, giving a 2-cycle minimum with 1 stall cycle.
- Upstream holds its inputs stable while stall_o=1; the block relies on this and does not latch request fields.
- Reset asserted during WAIT_RSP: the FSM returns to IDLE and a late response is ignored.

## Structure
- Shared package: WBSEL_ALU/WBSEL_MEM/WBSEL_PC, funct3 size codes, FSM state encoding.
- One sub-module, lsu_align, is combinational. It generates store be/wdata and extracts and extends load data.
- mem_stage contains the FSM, stall logic and MEM/WB register.

## Test plan
- ALU op, valid_i=1, alu_out_i=0x1234: next cycle alu_out_o=0x1234, valid_o=1, stall_o never set.
- SB at 0x103, rs2=0xAB, ready held low 2 cycles: stall_o=1 for 2 cycles. Then be=4'b1000, wdata=0xABABABAB, dmem_addr=0x100, and MEM/WB captures on the accept edge.
- LH at 0x102, response after 3 cycles with rdata=0x8001_0000: mem_rdata_o=0xFFFF8001. LHU gives 0x00008001.
- LW at 0x101: no request, misalign_o pulses once, valid_o=1, rf_w_en_o=0.
- Back-to-back LW, LW, ALU with single-cycle responses: each load stalls exactly 1 cycle, ordering is preserved and no bubble is lost.
- Reset low during WAIT_RSP with a response arriving after release: outputs are 0 and the response is ignored.
